regfile_wb_arbiter: RTL and testbench

Writeback arbiter and sequencer for the 32×32 register file. It accepts write requests from two producers: the ALU writeback (source 0) and the memory/load writeback (source 1). Each request is buffered in a per-source FIFO, and one write per cycle is issued onto the register file's single write port (writeReg / writeData / CONTROL_REGWRITE). A pending-write mask is exported so issue logic can stall on outstanding writes.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/wb_fifo.sv | 71 +++++++
 rtl/regfile_wb_arbiter.sv | 143 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package wb_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned ZERO_REG = 31;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_t;

   typedef struct packed {
      logic [ADDR_W-1:0] idx;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   // One-hot of a register index; the zero register never contributes.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] r);
      if (r == ADDR_W'(ZERO_REG)) begin
         reg_onehot = '0;
      end else begin
         reg_onehot = NUM_REGS'(1) << r;
      end
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source writeback request FIFO with a per-entry valid/index view
// used to build the pending-write mask.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          push,
   input  wb_entry_t                     push_entry,
   input  logic                          pop,
   output logic                          full,
   output logic                          empty,
   output wb_entry_t                     head,
   output logic [DEPTH-1:0]              ent_valid,
   output logic [DEPTH-1:0][ADDR_W-1:0]  ent_idx
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;
   wb_entry_t        mem [DEPTH];

   // A full FIFO refuses a push even when it pops in the same cycle.
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   // Slot i is live when its distance from the read pointer is below count.
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         ent_valid[i] = CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count;
         ent_idx[i]   = mem[i].idx;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter feeding the register file's single write port.
// WB_ROUND_ROBIN_EN selects round-robin; otherwise memory wins every tie.
module regfile_wb_arbiter #(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned DATA_W = wb_pkg::DATA_W,
   parameter int unsigned ADDR_W = wb_pkg::ADDR_W
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         alu_valid,
   output logic                         alu_ready,
   input  logic [ADDR_W-1:0]            alu_reg,
   input  logic [DATA_W-1:0]            alu_data,
   input  logic                         mem_valid,
   output logic                         mem_ready,
   input  logic [ADDR_W-1:0]            mem_reg,
   input  logic [DATA_W-1:0]            mem_data,
   output logic [ADDR_W-1:0]            writeReg,
   output logic [DATA_W-1:0]            writeData,
   output logic                         CONTROL_REGWRITE,
   output logic [wb_pkg::NUM_REGS-1:0]  pend_mask,
   output logic                         idle
);

   wb_pkg::wb_entry_t alu_entry, mem_entry;
   wb_pkg::wb_entry_t alu_head, mem_head;
   logic alu_full, alu_empty, mem_full, mem_empty;
   logic alu_push, mem_push;
   logic grant_alu, grant_mem;
   logic [DEPTH-1:0]             alu_ent_valid, mem_ent_valid;
   logic [DEPTH-1:0][ADDR_W-1:0] alu_ent_idx, mem_ent_idx;

   assign alu_ready = !alu_full;
   assign mem_ready = !mem_full;

   // Zero-register writes complete the handshake but are dropped here.
   assign alu_push = alu_valid && alu_ready && (alu_reg != ADDR_W'(wb_pkg::ZERO_REG));
   assign mem_push = mem_valid && mem_ready && (mem_reg != ADDR_W'(wb_pkg::ZERO_REG));

   assign alu_entry.idx  = alu_reg;
   assign alu_entry.data = alu_data;
   assign mem_entry.idx  = mem_reg;
   assign mem_entry.data = mem_data;

   wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (alu_push),
      .push_entry (alu_entry),
      .pop        (grant_alu),
      .full       (alu_full),
      .empty      (alu_empty),
      .head       (alu_head),
      .ent_valid  (alu_ent_valid),
      .ent_idx    (alu_ent_idx)
   );

   wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (mem_push),
      .push_entry (mem_entry),
      .pop        (grant_mem),
      .full       (mem_full),
      .empty      (mem_empty),
      .head       (mem_head),
      .ent_valid  (mem_ent_valid),
      .ent_idx    (mem_ent_idx)
   );

`ifdef WB_ROUND_ROBIN_EN
   wb_pkg::src_t last_grant;

   // Reset to MEM so the ALU wins the first tie.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= wb_pkg::SRC_MEM;
      end else if (grant_alu) begin
         last_grant <= wb_pkg::SRC_ALU;
      end else if (grant_mem) begin
         last_grant <= wb_pkg::SRC_MEM;
      end
   end

   always_comb begin
      grant_alu = 1'b0;
      grant_mem = 1'b0;
      if (!alu_empty && !mem_empty) begin
         if (last_grant == wb_pkg::SRC_ALU) begin
            grant_mem = 1'b1;
         end else begin
            grant_alu = 1'b1;
         end
      end else begin
         grant_alu = !alu_empty;
         grant_mem = !mem_empty;
      end
   end
`else
   always_comb begin
      grant_alu = 1'b0;
      grant_mem = 1'b0;
      grant_mem = !mem_empty;
      grant_alu = !alu_empty && mem_empty;
   end
`endif

   // Output stage: index/data hold their last value when nothing is granted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         CONTROL_REGWRITE <= 1'b0;
         writeReg         <= '0;
         writeData        <= '0;
      end else begin
         CONTROL_REGWRITE <= grant_alu || grant_mem;
         if (grant_mem) begin
            writeReg  <= mem_head.idx;
            writeData <= mem_head.data;
         end else if (grant_alu) begin
            writeReg  <= alu_head.idx;
            writeData <= alu_head.data;
         end
      end
   end

   always_comb begin
      pend_mask = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (alu_ent_valid[i]) begin
            pend_mask = pend_mask | wb_pkg::reg_onehot(alu_ent_idx[i]);
         end
         if (mem_ent_valid[i]) begin
            pend_mask = pend_mask | wb_pkg::reg_onehot(mem_ent_idx[i]);
         end
      end
      if (CONTROL_REGWRITE) begin
         pend_mask = pend_mask | wb_pkg::reg_onehot(writeReg);
      end
   end

   assign idle = alu_empty && mem_empty && !CONTROL_REGWRITE;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter; expectations follow WB_ROUND_ROBIN_EN.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid, mem_valid;
   logic        alu_ready, mem_ready;
   logic [4:0]  alu_reg, mem_reg;
   logic [31:0] alu_data, mem_data;
   logic [4:0]  writeReg;
   logic [31:0] writeData;
   logic        CONTROL_REGWRITE;
   logic [31:0] pend_mask;
   logic        idle;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

`ifdef WB_ROUND_ROBIN_EN
   int         tie_len        = 6;
   logic [4:0] tie_order [8]  = '{5'd1, 5'd10, 5'd2, 5'd11, 5'd3, 5'd12, 5'd4, 5'd13};
   bit         exp_alu_rdy [8] = '{1, 1, 1, 0, 1, 0, 0, 0};
   bit         exp_mem_rdy [8] = '{1, 1, 0, 1, 0, 1, 0, 0};
   logic [4:0] rst_first_reg  = 5'd5;
`else
   int         tie_len        = 8;
   logic [4:0] tie_order [8]  = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd1, 5'd2, 5'd3, 5'd4};
   bit         exp_alu_rdy [8] = '{1, 1, 0, 0, 0, 0, 1, 1};
   bit         exp_mem_rdy [8] = '{1, 1, 1, 1, 1, 1, 1, 1};
   logic [4:0] rst_first_reg  = 5'd15;
`endif

   regfile_wb_arbiter #(.DEPTH(2), .DATA_W(32), .ADDR_W(5)) dut (
      .clk              (clk),
      .reset_n          (rst_n),
      .alu_valid        (alu_valid),
      .alu_ready        (alu_ready),
      .alu_reg          (alu_reg),
      .alu_data         (alu_data),
      .mem_valid        (mem_valid),
      .mem_ready        (mem_ready),
      .mem_reg          (mem_reg),
      .mem_data         (mem_data),
      .writeReg         (writeReg),
      .writeData        (writeData),
      .CONTROL_REGWRITE (CONTROL_REGWRITE),
      .pend_mask        (pend_mask),
      .idle             (idle)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] data_of(input logic [4:0] r);
      return (r < 5'd10) ? 32'h100 + 32'(r) : 32'h200 + 32'(r);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_we"},    32'(CONTROL_REGWRITE), 32'd0);
      chk({tag, "_reg"},   32'(writeReg), 32'd0);
      chk({tag, "_data"},  writeData, 32'd0);
      chk({tag, "_pend"},  pend_mask, 32'd0);
      chk({tag, "_idle"},  32'(idle), 32'd1);
      chk({tag, "_ardy"},  32'(alu_ready), 32'd1);
      chk({tag, "_mrdy"},  32'(mem_ready), 32'd1);
   endtask

   task automatic drain(input string tag);
      int t = 0;
      while (exp_q.size() != 0 && t < 30) begin
         step();
         t++;
      end
      chk({tag, "_drain_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: every issued write must match the next scoreboard entry.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && CONTROL_REGWRITE === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual reg=%0d data=%0h required=no write",
                     writeReg, writeData);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wb_reg", 32'(writeReg), 32'(mon_e.r));
            chk("wb_data", writeData, mon_e.d);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int  ai, mi, cyc;
      bit  a_acc, m_acc;
      rst_n = 1'b0;
      alu_valid = 1'b0; mem_valid = 1'b0;
      alu_reg = '0; mem_reg = '0; alu_data = '0; mem_data = '0;
      step(); step();
      chk_reset_vals("rst_hold");
      rst_n = 1'b1;
      step();
      chk_reset_vals("rst_rel");

      // Single ALU write: visible one cycle after acceptance, pending two cycles.
      alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'd15;
      exp_q.push_back('{r: 5'd3, d: 32'd15});
      step();
      alu_valid = 1'b0;
      chk("t1_pend_q",  pend_mask, 32'h8);
      chk("t1_we_q",    32'(CONTROL_REGWRITE), 32'd0);
      chk("t1_idle_q",  32'(idle), 32'd0);
      step();
      chk("t1_we",      32'(CONTROL_REGWRITE), 32'd1);
      chk("t1_reg",     32'(writeReg), 32'd3);
      chk("t1_data",    writeData, 32'd15);
      chk("t1_pend_o",  pend_mask, 32'h8);
      step();
      chk("t1_we_off",  32'(CONTROL_REGWRITE), 32'd0);
      chk("t1_hold",    32'(writeReg), 32'd3);
      chk("t1_pend_clr", pend_mask, 32'd0);
      chk("t1_idle",    32'(idle), 32'd1);

      // Zero-register write: accepted, never issued, never pending.
      alu_valid = 1'b1; alu_reg = 5'd31; alu_data = 32'hDEAD;
      chk("t3_ready", 32'(alu_ready), 32'd1);
      step();
      alu_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("t3_we",   32'(CONTROL_REGWRITE), 32'd0);
         chk("t3_pend", pend_mask, 32'd0);
         chk("t3_idle", 32'(idle), 32'd1);
         step();
      end

      // Both sources valid every cycle.
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back('{r: tie_order[k], d: data_of(tie_order[k])});
      end
      ai = 0; mi = 0; cyc = 0;
      while ((ai < 4 || mi < 4) && cyc < 20) begin
         alu_valid = (ai < 4);
         alu_reg   = 5'(1 + ai);
         alu_data  = data_of(5'(1 + ai));
         mem_valid = (mi < 4);
         mem_reg   = 5'(10 + mi);
         mem_data  = data_of(5'(10 + mi));
         if (cyc < 8) begin
            chk("t2_alu_ready", 32'(alu_ready), 32'(exp_alu_rdy[cyc]));
            chk("t2_mem_ready", 32'(mem_ready), 32'(exp_mem_rdy[cyc]));
         end
         a_acc = alu_valid && alu_ready;
         m_acc = mem_valid && mem_ready;
         step();
         if (a_acc) ai++;
         if (m_acc) mi++;
         cyc++;
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      chk("t2_accept_cycles", 32'(cyc), 32'(tie_len));
      drain("t2");
      step();
      chk("t2_idle", 32'(idle), 32'd1);
      chk("t2_pend", pend_mask, 32'd0);

      // Reset with writes queued and one issued: flush everything.
      alu_valid = 1'b1; alu_reg = 5'd5;  alu_data = data_of(5'd5);
      mem_valid = 1'b1; mem_reg = 5'd15; mem_data = data_of(5'd15);
      exp_q.push_back('{r: rst_first_reg, d: data_of(rst_first_reg)});
      step();
      alu_reg = 5'd6;  alu_data = data_of(5'd6);
      mem_reg = 5'd16; mem_data = data_of(5'd16);
      step();
      alu_valid = 1'b0; mem_valid = 1'b0;
      chk("t5_pend_pre", pend_mask, 32'h0001_8060);
      chk("t5_idle_pre", 32'(idle), 32'd0);
      chk("t5_we_pre",   32'(CONTROL_REGWRITE), 32'd1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("t5_async");
      step(); step();
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("t5_post_we",   32'(CONTROL_REGWRITE), 32'd0);
         chk("t5_post_pend", pend_mask, 32'd0);
         step();
      end
      chk("final_queue_left", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
